// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the single-port memory side of dmem_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface dmem_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        uns0, uns1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
               size0, size1, uns0, uns1, mem_RD,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_A, mem_WD, mem_WE
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
               size0, size1, uns0, uns1, mem_RD,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port word memory (async read, sync write).
// Sub-word stores are done as read-modify-write; sub-word loads are lane-extracted and extended.
module dmem_arbiter #(
    parameter bit PRIORITY_RR = 1'b1,
    parameter int MEM_WORDS   = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR} state_t;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_t      state_q;
    logic        last_grant_q;
    logic        port_q;
    logic        rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, merge_q;

    logic        win1, gnt0, gnt1;
    logic        req_err, done, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] mem_a, mem_wd;
    logic        mem_we;

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] a,
                                                 input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] a, input logic half);
        logic [31:0] r;
        r = word;
        if (half) r[{a[1], 4'b0000} +: 16] = wd[15:0];
        else      r[{a, 3'b000} +: 8]      = wd[7:0];
        return r;
    endfunction

    // Round-robin: on a tie the port that did not win last time gets the grant.
    assign win1 = bus.req1 & (~bus.req0 | (PRIORITY_RR & ~last_grant_q));
    assign gnt0 = (state_q == IDLE) & bus.req0 & ~win1;
    assign gnt1 = (state_q == IDLE) & win1;

    assign req_err = (size_q == 2'b11)
                   | ((size_q == 2'b01) & addr_q[0])
                   | ((size_q == 2'b10) & (|addr_q[1:0]))
                   | ({2'b00, addr_q[31:2]} >= MEM_WORDS_W);

    assign done     = ((state_q == ACCESS) & (req_err | ~we_q | (size_q == 2'b10)))
                    | (state_q == RMW_WR);
    assign rsp_err  = (state_q == ACCESS) & req_err;
    assign rsp_data = ((state_q == ACCESS) & ~req_err & ~we_q)
                    ? extract_lane(bus.mem_RD, addr_q[1:0], size_q, uns_q) : 32'b0;

    // Memory strobes are decoded from state so reset drops mem_WE immediately.
    always_comb begin
        mem_a  = 32'b0;
        mem_wd = 32'b0;
        mem_we = 1'b0;
        case (state_q)
            ACCESS: if (!req_err) begin
                mem_a = {addr_q[31:2], 2'b00};
                if (we_q && size_q == 2'b10) begin
                    mem_we = 1'b1;
                    mem_wd = wdata_q;
                end
            end
            RMW_WR: begin
                mem_a  = {addr_q[31:2], 2'b00};
                mem_we = 1'b1;
                mem_wd = merge_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= 32'b0;
            rdata1_q     <= 32'b0;
        end else begin
            rvalid0_q <= done & ~port_q;
            rvalid1_q <= done & port_q;
            err0_q    <= done & ~port_q & rsp_err;
            err1_q    <= done & port_q & rsp_err;
            rdata0_q  <= (done & ~port_q) ? rsp_data : 32'b0;
            rdata1_q  <= (done & port_q) ? rsp_data : 32'b0;
            case (state_q)
                IDLE: if (gnt0 || gnt1) begin
                    state_q      <= ACCESS;
                    port_q       <= gnt1;
                    last_grant_q <= gnt1;
                end
                ACCESS: state_q <= done ? IDLE : RMW_WR;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request fields and the RMW merge word are pure data; state guards their use.
    always_ff @(posedge clk) begin
        if (gnt0 || gnt1) begin
            we_q    <= gnt1 ? bus.we1    : bus.we0;
            addr_q  <= gnt1 ? bus.addr1  : bus.addr0;
            wdata_q <= gnt1 ? bus.wdata1 : bus.wdata0;
            size_q  <= gnt1 ? bus.size1  : bus.size0;
            uns_q   <= gnt1 ? bus.uns1   : bus.uns0;
        end
        if (state_q == ACCESS)
            merge_q <= merge_lane(bus.mem_RD, wdata_q, addr_q[1:0], size_q[0]);
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;
    assign bus.mem_A   = mem_a;
    assign bus.mem_WD  = mem_wd;
    assign bus.mem_WE  = mem_we;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer for the single-port, word-addressed data memory. The memory has an asynchronous read and a synchronous word-only write. Port 0 serves the core load/store unit; port 1 serves the DMA/debug master. The block grants one requester at a time and performs byte/halfword stores by read-modify-write. It also extracts and sign/zero-extends sub-word loads and flags illegal accesses.

Parameters:
PRIORITY_RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
MEM_WORDS, 128, depth of the memory in 32-bit words; addresses at or beyond MEM_WORDS*4 are errors.

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req0 / req1  in  1  access request, held until granted
we0 / we1  in  1  1 = store, 0 = load
addr0 / addr1  in  32  byte address
wdata0 / wdata1  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
size0 / size1  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
uns0 / uns1  in  1  load zero-extend when 1, sign-extend when 0
gnt0 / gnt1  out  1  combinational accept, high in the cycle the request is captured
rvalid0 / rvalid1  out  1  registered one-cycle completion pulse
rdata0 / rdata1  out  32  registered load result; 0 for stores and errors
err0 / err1  out  1  registered, coincident with rvalid; marks an illegal access
mem_A  out  32  memory byte address, word-aligned (bits [1:0] = 0)
mem_WD  out  32  memory write data
mem_WE  out  1  memory write enable
mem_RD  in  32  memory asynchronous read data

Behaviour:
- Reset: state IDLE, last_grant = 1 (so port 0 wins the first tie). All outputs are 0, including mem_WE.
- mem_WE is decoded from state, so asserting rst_n low forces it to 0 immediately.
- States are IDLE, ACCESS and RMW_WR.
- IDLE:
  - Outputs mem_A = 0, mem_WD = 0, mem_WE = 0.
  - If any req is high, arbitrate. With round-robin and both requesting, the port not equal to last_grant wins. With a single requester, that port wins.
  - Assert gnt for the winner only. On the clock edge, latch we/addr/wdata/size/uns/port, update last_grant, and go to ACCESS.
- Error check on the latched request: size = 11, half with addr[0] = 1, word with addr[1:0] != 0, or addr[31:2] >= MEM_WORDS.
  - On error, ACCESS keeps mem_WE = 0. At the edge, rvalid = 1, err = 1, rdata = 0, then go to IDLE.
- ACCESS (no error): mem_A = {addr[31:2], 2'b00}.
  - Load: at the edge, register the extracted lane of mem_RD into rdata, pulse rvalid, go to IDLE.
    - Byte lane starts at bit addr[1:0]*8; half lane starts at bit addr[1]*16.
    - Extend with the sign bit unless uns is 1.
  - Word store: mem_WE = 1, mem_WD = wdata. At the edge, pulse rvalid with rdata = 0, go to IDLE.
  - Sub-word store: mem_WE = 0. Register merge = mem_RD with the target lane replaced by wdata[7:0] or wdata[15:0], go to RMW_WR.
- RMW_WR: mem_A held, mem_WE = 1, mem_WD = merge. At the edge, pulse rvalid, go to IDLE.
- Timing:
  - Load or word store: gnt in cycle N, rvalid in cycle N+2.
  - Sub-word store: rvalid in cycle N+3.
  - IDLE may grant in the same cycle rvalid is high, so back-to-back throughput is one access per 2 cycles (3 for sub-word stores).
- Requester rules: keep fields stable while req is high and gnt is low. req may drop or change after gnt. gnt is never given outside IDLE.
- Reset mid-operation: the transaction is aborted, with no write commit and no rvalid. last_grant returns to 1.

Test Plan:
- Port 0 SW 0xDEADBEEF at 0x10, then LW 0x10 → store rvalid 2 cycles after gnt with rdata 0; load rdata0 = 0xDEADBEEF with err0 = 0.
- SB 0xAA at 0x13 over 0xDEADBEEF → mem_WE high only in RMW_WR, word becomes 0xAAADBEEF. Then LB 0x13 = 0xFFFFFFAA, LBU 0x13 = 0x000000AA, LH 0x12 = 0xFFFFAAAD, LHU 0x10 = 0x0000BEEF.
- req0 and req1 held high for 8 grants with PRIORITY_RR = 1 → grant order 0,1,0,1,…. With PRIORITY_RR = 0 → only port 0 granted while req0 is high.
- LW 0x02, LH 0x01, SW 0x200, size = 11 → each gives rvalid = 1, err = 1, rdata = 0, and mem_WE stays 0 throughout.
- rst_n pulled low during ACCESS of an SH to 0x20 → mem_WE never rises, word 0x20 is unchanged, no rvalid; the next tie is granted to port 0.
- Port 1 issues 4 consecutive LWs with req1 held → gnt1 every 2nd cycle, each rvalid1 2 cycles after its gnt1 with the correct data.
